// File: rtl/ram_arbiter.sv
// ram_arbiter: initiator side of a single-port synchronous RAM shared by the
// CPU (port 0, read/write) and the video fetch (port 1, read-only).
// Each port gets at most one access in flight; the ack follows one cycle after
// the grant and returns the RAM's registered read data.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN selects round-robin on
// conflicts; when undefined, video (port 1) wins every conflict.
module ram_arbiter #(
   parameter int unsigned AW = 14
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req0,
   input  logic          w0,
   input  logic [AW-1:0] a0,
   input  logic [7:0]    d0,
   output logic          ack0,
   output logic [7:0]    q0,
   input  logic          req1,
   input  logic [AW-1:0] a1,
   output logic          ack1,
   output logic [7:0]    q1,
   output logic [AW-1:0] ram_a,
   output logic [7:0]    ram_d,
   output logic          ram_w,
   input  logic [7:0]    ram_q
);

   localparam int unsigned DW = 8;

   // The ack register doubles as the in-flight flag: it is set by the grant in
   // cycle N and is high exactly during cycle N+1, blocking a re-issue there.
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [DW-1:0] q0_q, q0_d;
   logic [DW-1:0] q1_q, q1_d;
   logic          elig0_c, elig1_c;
   logic          gnt0_c, gnt1_c;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   // 1 = port 1 was granted most recently
   logic          last_q, last_d;
`endif

   // Grant decision from registered in-flight state plus live requests
   always_comb begin
      elig0_c = req0 & ~ack0_q;
      elig1_c = req1 & ~ack1_q;
      gnt0_c  = 1'b0;
      gnt1_c  = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (elig0_c && elig1_c) begin
         gnt0_c = last_q;
         gnt1_c = ~last_q;
      end else begin
         gnt0_c = elig0_c;
         gnt1_c = elig1_c;
      end
`else
      gnt1_c = elig1_c;
      gnt0_c = elig0_c & ~elig1_c;
`endif
   end

   // RAM drive: video address when idle, write strobe only for a CPU write
   always_comb begin
      ram_a = gnt0_c ? a0 : a1;
      ram_d = d0;
      ram_w = gnt0_c & w0 & reset;
   end

   // Next-state: ack follows grant; read data captured on its ack cycle
   always_comb begin
      ack0_d = gnt0_c;
      ack1_d = gnt1_c;
      q0_d   = ack0_q ? ram_q : q0_q;
      q1_d   = ack1_q ? ram_q : q1_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_d = last_q;
      if (gnt0_c) begin
         last_d = 1'b0;
      end else if (gnt1_c) begin
         last_d = 1'b1;
      end
`endif
   end

   // State registers; reset drops any pending ack
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         q0_q   <= '0;
         q1_q   <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_q <= 1'b1;
`endif
      end else begin
         ack0_q <= ack0_d;
         ack1_q <= ack1_d;
         q0_q   <= q0_d;
         q1_q   <= q1_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_q <= last_d;
`endif
      end
   end

   // Read data is valid during the ack cycle straight from the RAM register,
   // then held until the next ack of the same port
   always_comb begin
      ack0 = ack0_q;
      ack1 = ack1_q;
      q0   = ack0_q ? ram_q : q0_q;
      q1   = ack1_q ? ram_q : q1_q;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural registered RAM, reference memory and
// per-port expected-data queues filled when requests are issued.
`timescale 1ns/1ps
module tb_ram_arbiter;

   localparam int AW = 14;

   logic          clock, reset;
   logic          req0, w0, req1;
   logic [AW-1:0] a0, a1;
   logic [7:0]    d0;
   logic          ack0, ack1;
   logic [7:0]    q0, q1;
   logic [AW-1:0] ram_a;
   logic [7:0]    ram_d;
   logic          ram_w;
   logic [7:0]    ram_q;

   logic          pre_en;
   logic [AW-1:0] pre_a;
   logic [7:0]    pre_d;
   logic [7:0]    mem [0:(1<<AW)-1];

   logic [7:0]    ref_mem [logic [AW-1:0]];
   logic [7:0]    exp0 [$];
   logic [7:0]    exp1 [$];
   int            exp_port [$];
   int            n_cmp = 0;
   int            n_err = 0;

   ram_arbiter #(.AW(AW)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .w0(w0), .a0(a0), .d0(d0), .ack0(ack0), .q0(q0),
      .req1(req1), .a1(a1), .ack1(ack1), .q1(q1),
      .ram_a(ram_a), .ram_d(ram_d), .ram_w(ram_w), .ram_q(ram_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Registered single-port RAM; a write echoes its data on ram_q
   always @(posedge clock) begin
      if (pre_en) mem[pre_a] <= pre_d;
      else if (ram_w) mem[ram_a] <= ram_d;
      ram_q <= ram_w ? ram_d : mem[ram_a];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      pre_en = 1'b1; pre_a = a; pre_d = d;
      ref_mem[a] = d;
      @(posedge clock); #1;
      pre_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0 = 1'b1; w0 = 1'b1; a0 = 14'h0123; d0 = 8'hFF;
      req1 = 1'b1; a1 = 14'h0001;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         n_cmp++; if (ram_w !== 1'b0) begin n_err++; $display("FAIL rst_ram_w: got %b want 0", ram_w); end
         n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL rst_ack0: got %b want 0", ack0); end
         n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL rst_ack1: got %b want 0", ack1); end
         n_cmp++; if (q0 !== 8'h00) begin n_err++; $display("FAIL rst_q0: got %h want 00", q0); end
         n_cmp++; if (q1 !== 8'h00) begin n_err++; $display("FAIL rst_q1: got %h want 00", q1); end
      end
      req0 = 1'b0; req1 = 1'b0; w0 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic cpu_op(input logic w, input logic [AW-1:0] a, input logic [7:0] d);
      int lat;
      logic [7:0] e;
      req0 = 1'b1; w0 = w; a0 = a; d0 = d;
      if (w) ref_mem[a] = d;
      exp0.push_back(ref_mem[a]);
      #1;
      n_cmp++; if (ram_w !== w) begin n_err++; $display("FAIL cpu_ram_w: got %b want %b", ram_w, w); end
      n_cmp++; if (ram_a !== a) begin n_err++; $display("FAIL cpu_ram_a: got %h want %h", ram_a, a); end
      n_cmp++; if (ram_d !== d) begin n_err++; $display("FAIL cpu_ram_d: got %h want %h", ram_d, d); end
      lat = 0;
      do begin @(posedge clock); #1; lat++; end while (ack0 !== 1'b1 && lat < 8);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL cpu_latency: got %0d want 1", lat); end
      e = exp0.pop_front();
      n_cmp++; if (q0 !== e) begin n_err++; $display("FAIL cpu_q0: got %h want %h", q0, e); end
      req0 = 1'b0;
      @(posedge clock); #1;
      n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL cpu_ack_pulse: got %b want 0", ack0); end
      n_cmp++; if (q0 !== e) begin n_err++; $display("FAIL cpu_q0_hold: got %h want %h", q0, e); end
   endtask

   task automatic test_cpu_write_read();
      cpu_op(1'b1, 14'h0123, 8'hA5);
      cpu_op(1'b0, 14'h0123, 8'h00);
      cpu_op(1'b1, 14'h0000, 8'h3C);
      cpu_op(1'b0, 14'h0000, 8'h00);
   endtask

   task automatic test_video();
      int lat;
      logic [7:0] e;
      preload(14'h3FFF, 8'h5A);
      req1 = 1'b1; a1 = 14'h3FFF;
      exp1.push_back(ref_mem[14'h3FFF]);
      #1;
      n_cmp++; if (ram_w !== 1'b0) begin n_err++; $display("FAIL vid_ram_w: got %b want 0", ram_w); end
      n_cmp++; if (ram_a !== 14'h3FFF) begin n_err++; $display("FAIL vid_ram_a: got %h want 3fff", ram_a); end
      lat = 0;
      do begin @(posedge clock); #1; lat++; end while (ack1 !== 1'b1 && lat < 8);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL vid_latency: got %0d want 1", lat); end
      e = exp1.pop_front();
      n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL vid_q1: got %h want %h", q1, e); end
      req1 = 1'b0;
      @(posedge clock); #1;
      n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL vid_ack_pulse: got %b want 0", ack1); end
      n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL vid_q1_hold: got %h want %h", q1, e); end
   endtask

   // Both ports request together and stay requesting; acks must alternate
   task automatic test_conflict();
      int first, p;
      logic [7:0] e;
      preload(14'h0010, 8'h11);
      preload(14'h0020, 8'h22);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      first = 0;
`else
      first = 1;
`endif
      req0 = 1'b1; w0 = 1'b0; a0 = 14'h0010;
      req1 = 1'b1; a1 = 14'h0020;
      for (int i = 0; i < 6; i++) begin
         p = (i % 2 == 0) ? first : 1 - first;
         exp_port.push_back(p);
         if (p == 0) exp0.push_back(ref_mem[14'h0010]);
         else        exp1.push_back(ref_mem[14'h0020]);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         p = exp_port.pop_front();
         n_cmp++; if (ack0 !== (p == 0)) begin n_err++; $display("FAIL conf_ack0[%0d]: got %b want %b", i, ack0, p == 0); end
         n_cmp++; if (ack1 !== (p == 1)) begin n_err++; $display("FAIL conf_ack1[%0d]: got %b want %b", i, ack1, p == 1); end
         if (p == 0) begin
            e = exp0.pop_front();
            n_cmp++; if (q0 !== e) begin n_err++; $display("FAIL conf_q0[%0d]: got %h want %h", i, q0, e); end
         end else begin
            e = exp1.pop_front();
            n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL conf_q1[%0d]: got %h want %h", i, q1, e); end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clock); #1;
      n_cmp++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin n_err++; $display("FAIL conf_idle: got ack0=%b ack1=%b want 0 0", ack0, ack1); end
   endtask

   // Reset lands at the start of the ack cycle of a CPU read: the ack is lost
   task automatic test_reset_mid();
      req0 = 1'b1; w0 = 1'b0; a0 = 14'h0123; d0 = 8'h00;
      @(posedge clock);
      reset = 1'b0;
      req0 = 1'b0;
      #1;
      n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL mid_ack0: got %b want 0", ack0); end
      n_cmp++; if (q0 !== 8'h00) begin n_err++; $display("FAIL mid_q0: got %h want 00", q0); end
      @(posedge clock); #1;
      n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL mid_ack0_held: got %b want 0", ack0); end
      reset = 1'b1;
      cpu_op(1'b0, 14'h0123, 8'h00);
   endtask

   initial begin
      pre_en = 1'b0; pre_a = '0; pre_d = '0;
      req0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
      req1 = 1'b0; a1 = '0;
      reset = 1'b0;
      @(posedge clock); #1;
      test_reset();
      test_cpu_write_read();
      test_video();
      test_conflict();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
